// File: rtl/asl_pred_stabilizer_if.sv
// Frame input and letter output bundle between the argmax stage, the stabilizer and the display/UART consumer.
interface asl_pred_stabilizer_if;
    logic signed [7:0] data_in;
    logic [4:0]        idx_in;
    logic              valid_i;
    logic [4:0]        letter_idx_o;
    logic [7:0]        letter_ascii_o;
    logic              letter_valid_o;
    logic              letter_ready_i;
    logic              overflow_o;
    logic [7:0]        drop_cnt_o;

    modport slave (
        input  data_in, idx_in, valid_i, letter_ready_i,
        output letter_idx_o, letter_ascii_o, letter_valid_o, overflow_o, drop_cnt_o
    );

    modport master (
        output data_in, idx_in, valid_i, letter_ready_i,
        input  letter_idx_o, letter_ascii_o, letter_valid_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/asl_pred_stabilizer.sv
// Temporal filter on argmax results: emits a letter once the same class wins STABLE_COUNT
// consecutive confident frames, delivered through a one-entry valid/ready output register.
module asl_pred_stabilizer #(
    parameter int                NUM_CLASSES  = 24,
    parameter int                STABLE_COUNT = 4,
    parameter logic signed [7:0] CONF_THRESH  = 8'sh10
) (
    input  logic                  clk,
    input  logic                  resetn,
    asl_pred_stabilizer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [5:0] NUM_C   = 6'(NUM_CLASSES);
    localparam logic [3:0] RUN_TGT = 4'(STABLE_COUNT);

    // J and Z need motion, so the static alphabet skips J after index 8.
    function automatic logic [7:0] idx_to_ascii(input logic [4:0] idx);
        if (idx <= 5'd8)
            return 8'h41 + {3'b000, idx};
        else
            return 8'h42 + {3'b000, idx};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [4:0]        cand;
    logic [4:0]        cand_nxt;
    logic [3:0]        run;
    logic [3:0]        run_nxt;
    logic [4:0]        last_idx;
    logic [4:0]        last_idx_nxt;
    logic              last_vld;
    logic              last_vld_nxt;

    logic signed [7:0] score_p0;
    logic              accept_p0;
    logic              emit_p0;

    logic [4:0]        out_idx_p1;
    logic [7:0]        out_ascii_p1;
    logic              out_vld_p1;
    logic              ovf_p1;
    logic [7:0]        drop_cnt_p1;
    logic              pop;

    // ---- stage p0: frame qualification and candidate tracking ----
    assign score_p0  = bus.data_in;
    assign accept_p0 = ({1'b0, bus.idx_in} < NUM_C) && (score_p0 >= CONF_THRESH);

    always_comb begin
        state_nxt    = state;
        cand_nxt     = cand;
        run_nxt      = run;
        last_idx_nxt = last_idx;
        last_vld_nxt = last_vld;
        emit_p0      = 1'b0;
        if (bus.valid_i) begin
            if (!accept_p0) begin
                state_nxt    = ST_IDLE;
                run_nxt      = 4'd0;
                last_vld_nxt = 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cand_nxt  = bus.idx_in;
                        run_nxt   = 4'd1;
                        state_nxt = ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (bus.idx_in == cand) begin
                            run_nxt = run + 4'd1;
                            if (run_nxt == RUN_TGT) begin
                                // A letter already stabilized since the last rejection is not repeated.
                                if (!last_vld || (last_idx != cand)) begin
                                    emit_p0      = 1'b1;
                                    last_idx_nxt = cand;
                                    last_vld_nxt = 1'b1;
                                end
                                state_nxt = ST_LOCKED;
                            end
                        end else begin
                            cand_nxt = bus.idx_in;
                            run_nxt  = 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (bus.idx_in != cand) begin
                            cand_nxt  = bus.idx_in;
                            run_nxt   = 4'd1;
                            state_nxt = ST_TRACK;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        run_nxt   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cand     <= 5'd0;
            run      <= 4'd0;
            last_idx <= 5'd0;
            last_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            run      <= run_nxt;
            last_idx <= last_idx_nxt;
            last_vld <= last_vld_nxt;
        end
    end

    // ---- stage p1: one-entry output register with drop accounting ----
    assign pop = out_vld_p1 & bus.letter_ready_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_idx_p1   <= 5'd0;
            out_ascii_p1 <= 8'd0;
            out_vld_p1   <= 1'b0;
            ovf_p1       <= 1'b0;
            drop_cnt_p1  <= 8'd0;
        end else begin
            ovf_p1 <= 1'b0;
            if (emit_p0 && (!out_vld_p1 || pop)) begin
                out_idx_p1   <= cand;
                out_ascii_p1 <= idx_to_ascii(cand);
                out_vld_p1   <= 1'b1;
            end else if (emit_p0) begin
                ovf_p1      <= 1'b1;
                drop_cnt_p1 <= sat_inc8(drop_cnt_p1);
            end else if (pop) begin
                out_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.letter_idx_o   = out_idx_p1;
    assign bus.letter_ascii_o = out_ascii_p1;
    assign bus.letter_valid_o = out_vld_p1;
    assign bus.overflow_o     = ovf_p1;
    assign bus.drop_cnt_o     = drop_cnt_p1;

endmodule

// File: doc/asl_pred_stabilizer.md
# asl_pred_stabilizer

Temporal filter directly downstream of the 24-class argmax stage. Takes one winning class index and score per classified frame. Rejects low-confidence or out-of-range results. Emits a letter only after the same class has won `STABLE_COUNT` consecutive accepted frames. Stable letters are delivered through a one-entry valid/ready output register, carrying both the class index and its ASCII code, to the display/UART consumer.

## Interface
- `NUM_CLASSES`, default 24: valid class indices are 0..NUM_CLASSES-1.
- `STABLE_COUNT`, default 4: consecutive identical accepted frames needed to emit; legal range 2..15.
- `CONF_THRESH`, default 8'sh10: minimum winning score, compared as a signed 8-bit value.
- `clk` input 1: single clock.
- `resetn` input 1: **asynchronous, active-low reset**.
- `data_in` input 8: winning score, signed two's complement.
- `idx_in` input 5: winning class index.
- `valid_i` input 1: one-cycle strobe per frame result. May assert every cycle.
- `letter_idx_o` output 5: emitted class index.
- `letter_ascii_o` output 8: ASCII code of the emitted letter.
- `letter_valid_o` output 1: output register holds an undelivered letter.
- `letter_ready_i` input 1: consumer accepts the letter when high together with `letter_valid_o`.
- `overflow_o` output 1: one-cycle pulse when an emission is dropped because the output register is full.
- `drop_cnt_o` output 8: saturating count of dropped emissions.

## Operation
- **Frame acceptance.** A frame (`valid_i`=1) is accepted when `idx_in` < NUM_CLASSES and `$signed(data_in)` >= CONF_THRESH. Any other frame is rejected. Cycles with `valid_i`=0 have no effect on the filter.
- **State machine.** Three states, plus `cand` (5b), `run` (4b) and `last` (5b + valid flag).
  - IDLE: no candidate. An accepted frame sets `cand`=idx, `run`=1, and moves to TRACK.
  - TRACK:
    - Accepted frame with idx==`cand`: `run`+1.
    - Accepted frame with a different idx: `cand`=idx, `run`=1, stay in TRACK.
    - When `run` becomes STABLE_COUNT: if `last` is invalid or `last`≠`cand`, request emission and set `last`=`cand`. Move to LOCKED in either case.
  - LOCKED:
    - Same idx: no change (`run` saturates at STABLE_COUNT).
    - Different accepted idx: `cand`=idx, `run`=1, go to TRACK.
  - Rejected frame in any state: go to IDLE, `run`=0, invalidate `last`. Lowering the hand therefore permits repeating a letter (for example "LL").
- **ASCII mapping.** The 24 static ASL letters exclude J and Z.
  - idx 0..8 → 0x41+idx (A..I).
  - idx 9..23 → 0x42+idx (K..Y). Example: idx 9 → 0x4B 'K'; idx 23 → 0x59 'Y'.
- **Output register.** One entry.
  - An emission request loads `letter_idx_o`/`letter_ascii_o` and sets `letter_valid_o` when the register is empty or is being popped this cycle (`letter_valid_o & letter_ready_i`).
  - Otherwise the new letter is dropped, the held letter is unchanged, `overflow_o` pulses, and `drop_cnt_o` increments, saturating at 255.
  - While `letter_valid_o`=1 and no pop occurs, index and ASCII outputs hold stable.
  - A pop with no simultaneous load clears `letter_valid_o`. Data outputs keep their last value.
- **Reset.** `resetn` low clears everything immediately, including mid-run or with a letter pending: state=IDLE, `run`=0, `cand`=0, `last` invalid, all outputs 0. A pending letter is lost.

## Timing
- `valid_i`/`data_in`/`idx_in` are sampled on the rising edge. Inputs are not held; no backpressure exists toward the argmax stage.
- Emission latency: `letter_valid_o` rises on the same edge that samples the STABLE_COUNT-th consecutive accepted frame. It is visible in the following cycle.
- Maximum emission rate is one letter per STABLE_COUNT accepted frames. With valid frames every cycle and `letter_ready_i` tied high, no drops occur.
- `overflow_o` is registered and high for exactly one cycle per dropped emission.
- Handshake transfer occurs on any edge where `letter_valid_o & letter_ready_i`. Pop and load on the same edge leave `letter_valid_o`=1 with the new letter.

## Test plan
- **Reset.** Assert `resetn`=0 mid-run with `letter_valid_o`=1 → all outputs 0 asynchronously. After release, 3 frames of idx 5 do not emit; a 4th does.
- **Basic emit.** 4 frames of idx 2, score 0x40, `letter_ready_i`=1 → one letter, idx 2, ASCII 0x43. A further 6 frames of idx 2 produce no emission.
- **Threshold and range.** Frame sequence idx 7 (0x40), idx 7 (0x40), idx 7 (0x0F), idx 7 (0x40)×3 → no emission. Adding a 4th frame → idx 7 emitted ('H'). Frames with score 0x80 (−128) or idx 24 are rejected.
- **J-skip mapping.** Stabilize idx 8, 9, 23 (separated by a different idx) → ASCII 0x49, 0x4B, 0x59.
- **Repeat letter.** Stabilize idx 10 ('L'), send one rejected frame, stabilize idx 10 again → two 'L' emissions. Without the rejected frame → only one.
- **Overflow and simultaneous pop.** With `letter_ready_i`=0, stabilize idx 0 then idx 1 → 'A' held, `overflow_o` one pulse, `drop_cnt_o`=1. Then raise `letter_ready_i` on the same edge a third emission (idx 2) occurs → 'A' popped, 'C' loaded, no drop, `drop_cnt_o` stays 1.
